// File: rtl/sar_search.sv
// Successive-approximation search: drives candidates to an external comparator
// and binary-searches 0..2^WIDTH-1 for the comparator's b operand.
module sar_search #(
  parameter int WIDTH  = 5,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] cmp_a,
  input  logic [1:0]       cmp_r,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       steps
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MAX_VAL     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] FIRST_MID   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [2:0]       SETTLE_LAST = 3'(SETTLE - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] cmp_a_q,  cmp_a_d;
  logic [2:0]       cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             found_q,  found_d;
  logic             err_q,    err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       steps_q,  steps_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cmp_a_d  = cmp_a_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    steps_d  = steps_q;
    sum      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = ZERO_VAL;
          hi_d     = MAX_VAL;
          cmp_a_d  = FIRST_MID;
          cnt_d    = 3'd0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = ZERO_VAL;
          steps_d  = 3'd0;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (cnt_q != SETTLE_LAST) begin
          cnt_d = cnt_q + 3'd1;
        end else begin
          cnt_d = 3'd0;
          if (steps_q != 3'd7) steps_d = steps_q + 3'd1;
          case (cmp_r)
            2'b00: begin
              result_d = cmp_a_q;
              found_d  = 1'b1;
              state_d  = DONE;
            end
            2'b01: begin
              // Candidate at the top of the range with a < b: nothing left above.
              if (cmp_a_q == MAX_VAL) state_d = DONE;
              else                    lo_d    = cmp_a_q + ONE_VAL;
            end
            2'b10: begin
              if (cmp_a_q == ZERO_VAL) state_d = DONE;
              else                     hi_d    = cmp_a_q - ONE_VAL;
            end
            default: begin
              err_d   = 1'b1;
              found_d = 1'b0;
              state_d = DONE;
            end
          endcase
          if (state_d == CMP) begin
            // Extra bit on the sum keeps lo+hi from wrapping.
            sum = {1'b0, lo_d} + {1'b0, hi_d};
            if (lo_d > hi_d) state_d = DONE;
            else             cmp_a_d = sum[WIDTH:1];
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      cmp_a_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cmp_a_q  <= cmp_a_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
      steps_q  <= steps_d;
    end
  end

  assign cmp_a  = cmp_a_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: two instances (SETTLE=1 and SETTLE=3), each
// driven by its own behavioural comparator.
module tb_sar_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start3;
  logic [4:0] a1, a3, res1, res3;
  logic [1:0] r1, r3;
  logic       busy1, busy3, done1, done3, found1, found3, err1, err3;
  logic [2:0] st1, st3;

  int b1, b3, mode1, mode3;
  int sel;
  int checks = 0;
  int errors = 0;

  sar_search #(.WIDTH(5), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmp_a(a1), .cmp_r(r1),
    .busy(busy1), .done(done1), .found(found1), .err(err1),
    .result(res1), .steps(st1)
  );

  sar_search #(.WIDTH(5), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cmp_a(a3), .cmp_r(r3),
    .busy(busy3), .done(done3), .found(found3), .err(err3),
    .result(res3), .steps(st3)
  );

  // mode: 0 compare with b, 1 force "less", 2 force invalid, 3 force "greater"
  function automatic logic [1:0] cmp_model(input logic [4:0] a, input int b, input int mode);
    if (mode == 1) return 2'b01;
    if (mode == 2) return 2'b11;
    if (mode == 3) return 2'b10;
    if (int'(a) == b) return 2'b00;
    if (int'(a) < b)  return 2'b01;
    return 2'b10;
  endfunction

  always_comb r1 = cmp_model(a1, b1, mode1);
  always_comb r3 = cmp_model(a3, b3, mode3);

  logic [4:0] a_s, res_s;
  logic       busy_s, done_s, found_s, err_s;
  logic [2:0] st_s;
  always_comb begin
    a_s = a1; res_s = res1; busy_s = busy1; done_s = done1;
    found_s = found1; err_s = err1; st_s = st1;
    if (sel == 3) begin
      a_s = a3; res_s = res3; busy_s = busy3; done_s = done3;
      found_s = found3; err_s = err3; st_s = st3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 3) start3 = v;
    else          start1 = v;
  endtask

  // One full search on the selected instance; seq holds the expected cmp_a
  // value seen after every edge during which busy is high.
  task automatic run(input string tag, input int b, input int mode,
                     input int seq[0:17], input int n, input int exp_edges,
                     input int exp_found, input int exp_err, input int exp_res,
                     input int exp_steps, input int poke);
    int got[$];
    int edges;
    @(negedge clk);
    if (sel == 3) begin b3 = b; mode3 = mode; end
    else          begin b1 = b; mode1 = mode; end
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    edges = 0;
    got = {};
    while (!done_s && edges < 100) begin
      if (busy_s) got.push_back(int'(a_s));
      if (poke != 0 && (edges == 2 || edges == 5)) set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      edges++;
    end
    chk({tag, " n_cmp"}, got.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s cmp_a[%0d]", tag, i), (i < got.size()) ? got[i] : -1, seq[i]);
    chk({tag, " latency"}, edges, exp_edges);
    chk({tag, " found"},  found_s, exp_found);
    chk({tag, " err"},    err_s, exp_err);
    chk({tag, " result"}, res_s, exp_res);
    chk({tag, " steps"},  st_s, exp_steps);
    chk({tag, " busy_at_done"}, busy_s, 0);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, done_s, 0);
    chk({tag, " found_held"}, found_s, exp_found);
    chk({tag, " steps_held"}, st_s, exp_steps);
  endtask

  int s8[0:17]   = '{15, 7, 11, 9, 8, 0,0,0,0,0,0,0,0,0,0,0,0,0};
  int s15[0:17]  = '{15, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int s31[0:17]  = '{15, 23, 27, 29, 30, 31, 0,0,0,0,0,0,0,0,0,0,0,0};
  int s0[0:17]   = '{15, 7, 3, 1, 0, 0,0,0,0,0,0,0,0,0,0,0,0,0};
  int s8x3[0:17] = '{15,15,15, 7,7,7, 11,11,11, 9,9,9, 8,8,8, 0,0,0};

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
    b1 = 0; b3 = 0; mode1 = 0; mode3 = 0; sel = 1;
    #2;
    chk("reset cmp_a", a1, 0);
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);
    chk("reset steps", st1, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run("b8",      8, 0, s8,  5, 6, 1, 0, 8,  5, 0);
    run("b15",    15, 0, s15, 1, 2, 1, 0, 15, 1, 0);
    run("b31",    31, 0, s31, 6, 7, 1, 0, 31, 6, 0);
    run("b0",      0, 0, s0,  5, 6, 1, 0, 0,  5, 0);
    run("force01", 0, 1, s31, 6, 7, 0, 0, 0,  6, 0);
    run("force11", 0, 2, s15, 1, 2, 0, 1, 0,  1, 0);
    run("force10", 0, 3, s0,  5, 6, 0, 0, 0,  5, 0);
    run("b8_poke", 8, 0, s8,  5, 6, 1, 0, 8,  5, 1);

    sel = 3;
    run("s3_b8",   8, 0, s8x3, 15, 16, 1, 0, 8, 5, 1);

    // Asynchronous reset mid-search on the SETTLE=1 instance.
    sel = 1;
    @(negedge clk);
    b1 = 31; mode1 = 0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst cmp_a", a1, 0);
    chk("arst busy", busy1, 0);
    chk("arst found", found1, 0);
    chk("arst result", res1, 0);
    chk("arst steps", st1, 0);
    chk("arst done", done1, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("arst no_done[%0d]", i), done1, 0);
      chk($sformatf("arst no_busy[%0d]", i), busy1, 0);
    end
    rst_n = 1'b1;
    run("after_rst", 8, 0, s8, 5, 6, 1, 0, 8, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have parameter WIDTH, default 5: width of the comparator operands and the search range 0..2^WIDTH-1.
REQ-002 SHALL have parameter SETTLE, default 1 (legal 1..7): cycles each candidate is held on cmp_a before cmp_r is sampled.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: request a new search; sampled only in IDLE.
REQ-006 SHALL have port cmp_a, output, WIDTH: candidate value driven to the external comparator's a input, registered.
REQ-007 SHALL have port cmp_r, input, 2: comparator result; 00 = a equals b, 01 = a less than b, 10 = a greater than b, 11 = invalid.
REQ-008 SHALL have port busy, output, 1: high while a search is in progress (CMP state).
REQ-009 SHALL have port done, output, 1: one-cycle pulse when a search ends.
REQ-010 SHALL have port found, output, 1: last search matched; valid from done until the next start.
REQ-011 SHALL have port err, output, 1: last search aborted on cmp_r = 11.
REQ-012 SHALL have port result, output, WIDTH: matched value; 0 when found = 0.
REQ-013 SHALL have port steps, output, 3: number of comparisons in the last search, saturating at 7.

Function
REQ-014 SHALL implement states IDLE, CMP and DONE; all outputs are registered.
REQ-015 SHALL, in IDLE with start = 1, load lo = 0 and hi = 2^WIDTH-1, then move to CMP.
REQ-016 On that same edge it SHALL also drive cmp_a = 2^(WIDTH-1)-1 and clear found, err, result and steps.
REQ-017 SHALL compute mid = (lo+hi)>>1 using a WIDTH+1-bit sum, so there is no overflow.
REQ-018 SHALL hold cmp_a stable for SETTLE cycles per comparison and sample cmp_r on the last of those cycles.
REQ-019 On that sample, steps SHALL increment by 1, saturating at 7.
REQ-020 On cmp_r = 00: result = cmp_a, found = 1, go to DONE.
REQ-021 On cmp_r = 01: lo = cmp_a+1.
REQ-022 On cmp_r = 01 with cmp_a = 2^WIDTH-1: go to DONE with found = 0 and err = 0.
REQ-023 On cmp_r = 10: hi = cmp_a-1.
REQ-024 On cmp_r = 10 with cmp_a = 0: go to DONE with found = 0 and err = 0.
REQ-025 On cmp_r = 11: err = 1, found = 0, go to DONE.
REQ-026 If an update leaves lo > hi, SHALL go to DONE with found = 0; otherwise SHALL drive cmp_a = the new mid and stay in CMP.
REQ-027 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy = 0 in DONE.
REQ-028 SHALL ignore start while in CMP or DONE; no queuing.
REQ-029 SHALL hold found, err, result, steps and cmp_a after DONE until the next accepted start.
REQ-030 SHALL end a search after at most WIDTH+1 comparisons (6 at default); latency from the start edge to done = 1 is steps*SETTLE + 1 clock edges.

Reset
REQ-031 SHALL, while rst_n = 0, force state IDLE and cmp_a = 0, busy = 0, done = 0, found = 0, err = 0, result = 0, steps = 0, lo = 0, hi = 0, irrespective of clk.
REQ-032 SHALL abandon any search in progress when rst_n is asserted; no done pulse is produced for the aborted search.
REQ-033 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-034 With WIDTH = 5, SETTLE = 1, behavioural comparator, b = 8, start -> cmp_a sequence 15, 7, 11, 9, 8, then done with found = 1, result = 8, steps = 5, done high 6 edges after start.
REQ-035 b = 15 -> single comparison; done 2 edges after start; found = 1, result = 15, steps = 1.
REQ-036 b = 31 -> cmp_a 15, 23, 27, 29, 30, 31; found = 1, steps = 6. b = 0 -> cmp_a 15, 7, 3, 1, 0; found = 1, steps = 5.
REQ-037 cmp_r forced to 01 -> cmp_a 15, 23, 27, 29, 30, 31, then done with found = 0, err = 0, steps = 6. cmp_r forced to 11 -> done after one comparison with err = 1, steps = 1.
REQ-038 SETTLE = 3, b = 8 -> each cmp_a value held 3 cycles; done 16 edges after start; start pulses during busy are ignored.
REQ-039 rst_n pulsed low mid-search, asynchronous to clk -> all outputs 0 immediately, no done pulse; a new start then completes normally.
